mul_seq: RTL
============

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 The block SHALL provide port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL provide port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL provide port Start, input, 1 bit: a request to begin a MUL, driven by the controller when opMul is set in the execute state.
REQ-004 The block SHALL provide port SrcA, input, 32 bits: the multiplicand (Rm operand).
REQ-005 The block SHALL provide port SrcB, input, 32 bits: the multiplier (Rs operand).
REQ-006 The block SHALL provide port Busy, output, 1 bit: high while an operation is in progress.
REQ-007 The block SHALL provide port Done, output, 1 bit: a single-cycle pulse signalling that the result is valid.
REQ-008 The block SHALL provide port Product, output, 32 bits: the low 32 bits of SrcA*SrcB, held stable until the next result.
REQ-009 The block SHALL provide port MulFlags, output, 4 bits: {N,Z,C,V} of Product, consumed by condlogic when FlagW is set.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, RUN and DONE; Busy SHALL be 1 exactly when the state is RUN, and Done SHALL be 1 exactly when the state is DONE.
REQ-011 In IDLE or DONE, when Start=1 the block SHALL latch SrcA into the multiplicand register, latch SrcB into the multiplier register, clear the accumulator, clear the 5-bit counter, and go to RUN.
REQ-012 In IDLE or DONE with Start=0, the state SHALL become or remain IDLE; DONE SHALL last exactly one cycle.
REQ-013 Each RUN cycle SHALL perform one shift-add step: if the multiplier LSB is 1, add the multiplicand to the accumulator modulo 2^32; shift the multiplicand left by 1; shift the multiplier right by 1 (logical); increment the counter.
REQ-014 RUN SHALL go to DONE after the step in which counter==31, giving 32 RUN cycles: Start high in cycle N produces RUN in cycles N+1..N+32 and Done=1 in cycle N+33.
REQ-015 Start while in RUN SHALL be ignored, with no change to operands, counter or outputs.
REQ-016 Product and MulFlags SHALL be registered and updated only on the transition into DONE; they SHALL hold their prior values during RUN and IDLE.
REQ-017 MulFlags SHALL be set as N=Product[31], Z=(Product==0), C=0, V=0.
REQ-018 Operands SHALL be treated as unsigned; the low 32 bits are identical for signed operands, so no sign handling is required.
REQ-019 A Start in DONE SHALL be accepted as a back-to-back operation; Done SHALL then deassert in the next cycle.

Reset
REQ-020 While reset=0, the block SHALL asynchronously force the state to IDLE and drive Busy=0, Done=0, Product=0 and MulFlags=4'b0100 (Z set, because Product=0); the accumulator, operand registers and counter SHALL be cleared.
REQ-021 A reset asserted mid-RUN SHALL abort the operation without producing a Done pulse; after release, the block SHALL accept a new Start from IDLE.

Configuration
REQ-022 With macro MUL_SEQ_EARLY_TERM_EN defined, RUN SHALL also go to DONE after any step that leaves the shifted multiplier register equal to 0, so latency is (index of the highest set bit of SrcB)+1 RUN cycles, with a minimum of 1 RUN cycle when SrcB=0.
REQ-023 Without MUL_SEQ_EARLY_TERM_EN, latency SHALL always be 32 RUN cycles; Product SHALL be identical in both builds.

Verification
REQ-024 The bench SHALL cover: SrcA=7, SrcB=6, Start in cycle N -> Busy in N+1..N+32, Done in N+33 only, Product=42, MulFlags=0000.
REQ-025 The bench SHALL cover: SrcA=SrcB=0xFFFFFFFF -> Product=0x00000001, MulFlags=0000; and SrcA=SrcB=0x00010000 -> Product=0, MulFlags=0100.
REQ-026 The bench SHALL cover: SrcA=0x80000000, SrcB=1 -> Product=0x80000000, MulFlags=1000; with MUL_SEQ_EARLY_TERM_EN, Done in N+2.
REQ-027 The bench SHALL cover: Start with SrcA=3, SrcB=5, then reset pulsed low at N+10 -> Busy=0, Done never pulses, Product=0; a new Start at N+15 with 3*5 -> Product=15.
REQ-028 The bench SHALL cover: Start with 3*5, then Start with 9*9 at N+5 (during RUN) -> the second Start is ignored and Product=15 at N+33; with MUL_SEQ_EARLY_TERM_EN, Done in N+4.
REQ-029 The bench SHALL cover: Start with 2*3, then Start with 4*5 held in the DONE cycle -> Product=6 in that cycle and Product=20 exactly 33 cycles later, with no IDLE cycle between the two operations.

Source files
------------

// File: rtl/mul_seq.sv
// Sequential 32x32 shift-add multiplier (low 32 bits); 32 RUN cycles then a one-cycle Done pulse.
// Define MUL_SEQ_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are all zero.
module mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Product,
  output logic [3:0]  MulFlags
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] mcand, mplier, acc;
  logic [4:0]  cnt;
  logic [31:0] acc_step, mplier_step;
  logic        last_step;
  logic        load;

  always_comb begin
    acc_step    = mplier[0] ? (acc + mcand) : acc;
    mplier_step = {1'b0, mplier[31:1]};
`ifdef MUL_SEQ_EARLY_TERM_EN
    last_step   = (cnt == 5'd31) || (mplier_step == 32'd0);
`else
    last_step   = (cnt == 5'd31);
`endif
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE, DONE: begin
        load      = Start;
        state_nxt = Start ? RUN : IDLE;
      end
      RUN:     if (last_step) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy = (state == RUN);
  assign Done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Start during RUN is ignored because load is only raised from IDLE/DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      Product  <= '0;
      MulFlags <= 4'b0100;
    end else if (load) begin
      mcand  <= SrcA;
      mplier <= SrcB;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_step;
      mcand  <= {mcand[30:0], 1'b0};
      mplier <= mplier_step;
      cnt    <= cnt + 5'd1;
      if (last_step) begin
        Product  <= acc_step;
        MulFlags <= {acc_step[31], (acc_step == 32'd0), 2'b00};
      end
    end
  end

endmodule
